// File: rtl/call_stack.sv
// call_stack
//   Return-address stack beside the program counter. A call saves pc+1 and
//   presents the jump target. A return pops the saved address and presents
//   it. loadAddr/nLoad are registered and drive the counter's parallel load.
//
// Ports
//   clk        rising-edge clock shared with the program counter
//   nReset     asynchronous active-low reset
//   pc         current program-counter value (address of the call)
//   target     call destination address
//   push, pop  request decode {push,pop}: 10 call, 01 return, 11 tail-call
//   clearErr   synchronous clear of the sticky error flags
//   loadAddr   address to load into the counter (registered)
//   nLoad      active-low load strobe, low one cycle per accepted request
//   count      number of valid entries (saturates at DEPTH)
//   empty/full combinational decodes of count
//   overflow   sticky, push while full
//   underflow  sticky, pop while empty

module call_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nReset,
  input  logic [WIDTH-1:0]           pc,
  input  logic [WIDTH-1:0]           target,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clearErr,
  output logic [WIDTH-1:0]           loadAddr,
  output logic                       nLoad,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [PW-1:0]    top;

  logic [WIDTH-1:0] ret_addr;
  logic [PW-1:0]    top_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] load_addr_nxt;
  logic             n_load_nxt;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic             ovf_set;
  logic             unf_set;
  logic             do_call;

  assign ret_addr = pc + WIDTH'(1);
  assign empty    = (count == '0);
  assign full     = (count == COUNT_MAX);

  always_comb begin
    top_nxt       = top;
    count_nxt     = count;
    load_addr_nxt = loadAddr;
    n_load_nxt    = 1'b1;
    wr_en         = 1'b0;
    wr_idx        = top;
    ovf_set       = 1'b0;
    unf_set       = 1'b0;
    do_call       = 1'b0;

    case ({push, pop})
      2'b10: do_call = 1'b1;
      2'b01: begin
        if (!empty) begin
          load_addr_nxt = stack_mem[top];
          n_load_nxt    = 1'b0;
          top_nxt       = top - PW'(1);
          count_nxt     = count - CW'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      2'b11: begin
        // A tail-call on an empty stack has no frame to replace, so it
        // degenerates to a plain call.
        if (!empty) begin
          wr_en         = 1'b1;
          wr_idx        = top;
          load_addr_nxt = target;
          n_load_nxt    = 1'b0;
        end else begin
          do_call = 1'b1;
        end
      end
      default: ;
    endcase

    if (do_call) begin
      // When full, the pointer wrap lands on the oldest entry and drops it.
      wr_en         = 1'b1;
      wr_idx        = top + PW'(1);
      top_nxt       = top + PW'(1);
      load_addr_nxt = target;
      n_load_nxt    = 1'b0;
      if (full) ovf_set = 1'b1;
      else      count_nxt = count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) stack_mem[i] <= '0;
      top       <= '0;
      count     <= '0;
      loadAddr  <= '0;
      nLoad     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) stack_mem[wr_idx] <= ret_addr;
      top       <= top_nxt;
      count     <= count_nxt;
      loadAddr  <= load_addr_nxt;
      nLoad     <= n_load_nxt;
      // A new error in the same cycle as clearErr leaves the flag set.
      overflow  <= (overflow  & ~clearErr) | ovf_set;
      underflow <= (underflow & ~clearErr) | unf_set;
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack
//   Self-checking bench for call_stack: directed scenarios followed by
//   random push/pop/clearErr traffic, compared against a queue-based model.

module tb_call_stack;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             nReset = 1'b0;
  logic [WIDTH-1:0] pc = '0;
  logic [WIDTH-1:0] target = '0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             clearErr = 1'b0;
  logic [WIDTH-1:0] loadAddr;
  logic             nLoad;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .nReset(nReset), .pc(pc), .target(target),
    .push(push), .pop(pop), .clearErr(clearErr),
    .loadAddr(loadAddr), .nLoad(nLoad), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: queue of saved return addresses, newest at the back
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_load = '0;
  logic             m_nload = 1'b1;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_load  = '0;
    m_nload = 1'b1;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_update(input logic pu, input logic po, input logic clr,
                              input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] ra;
    logic new_ovf, new_unf;
    ra = p + 1;
    new_ovf = 1'b0;
    new_unf = 1'b0;
    m_nload = 1'b1;
    if (pu && (!po || q.size() == 0)) begin
      if (q.size() == DEPTH) begin
        void'(q.pop_front());
        new_ovf = 1'b1;
      end
      q.push_back(ra);
      m_load  = t;
      m_nload = 1'b0;
    end else if (pu && po) begin
      q[q.size()-1] = ra;
      m_load  = t;
      m_nload = 1'b0;
    end else if (po) begin
      if (q.size() > 0) begin
        m_load  = q.pop_back();
        m_nload = 1'b0;
      end else begin
        new_unf = 1'b1;
      end
    end
    m_ovf = (m_ovf && !clr) || new_ovf;
    m_unf = (m_unf && !clr) || new_unf;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".nLoad"},     32'(nLoad),     32'(m_nload));
    chk({ctx, ".loadAddr"},  32'(loadAddr),  32'(m_load));
    chk({ctx, ".count"},     32'(count),     32'(q.size()));
    chk({ctx, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({ctx, ".full"},      32'(full),      32'(q.size() == DEPTH));
    chk({ctx, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({ctx, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // inputs change on the falling edge; outputs are checked one falling edge later
  task automatic step(input logic pu, input logic po, input logic clr,
                      input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] t,
                      input string ctx);
    push = pu; pop = po; clearErr = clr; pc = p; target = t;
    @(posedge clk);
    model_update(pu, po, clr, p, t);
    @(negedge clk);
    check_all(ctx);
  endtask

  logic [WIDTH-1:0] exp_ret [4];

  initial begin
    model_reset();
    nReset = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset");
    nReset = 1'b1;

    for (int i = 0; i < 5; i++) step(0, 0, 0, '0, '0, "idle");

    // basic call and return
    step(1, 0, 0, 12'h123, 12'h400, "call1");
    chk("call1.addr", 32'(loadAddr), 32'h400);
    step(0, 0, 0, '0, '0, "gap1");
    step(0, 1, 0, '0, '0, "ret1");
    chk("ret1.addr",  32'(loadAddr), 32'h124);
    chk("ret1.empty", 32'(empty), 32'd1);

    // overflow: fifth push drops the oldest frame
    for (int i = 1; i <= 5; i++)
      step(1, 0, 0, WIDTH'(i * 16), WIDTH'($urandom), "ovfpush");
    chk("ovf.flag",  32'(overflow), 32'd1);
    chk("ovf.full",  32'(full), 32'd1);
    chk("ovf.count", 32'(count), 32'd4);
    exp_ret[0] = 12'h051; exp_ret[1] = 12'h041; exp_ret[2] = 12'h031; exp_ret[3] = 12'h021;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, '0, '0, "ovfpop");
      chk("ovfpop.addr", 32'(loadAddr), 32'(exp_ret[i]));
    end

    // underflow and clear
    step(0, 1, 0, '0, '0, "unf");
    chk("unf.nLoad", 32'(nLoad), 32'd1);
    chk("unf.flag",  32'(underflow), 32'd1);
    step(0, 0, 1, '0, '0, "clr");
    chk("clr.unf", 32'(underflow), 32'd0);

    // return-address wrap
    step(1, 0, 0, 12'hFFF, 12'h010, "wrappush");
    step(0, 1, 0, '0, '0, "wrappop");
    chk("wrap.addr", 32'(loadAddr), 32'h000);

    // tail-call replaces the top frame
    step(1, 0, 0, 12'h100, 12'h500, "tcpush1");
    step(1, 0, 0, 12'h150, 12'h600, "tcpush2");
    step(1, 1, 0, 12'h200, 12'h300, "tail");
    chk("tail.addr",  32'(loadAddr), 32'h300);
    chk("tail.count", 32'(count), 32'd2);
    step(0, 1, 0, '0, '0, "tcpop1");
    chk("tcpop1.addr", 32'(loadAddr), 32'h201);
    step(0, 1, 0, '0, '0, "tcpop2");
    chk("tcpop2.addr", 32'(loadAddr), 32'h101);

    // tail-call on empty acts as a call
    step(1, 1, 0, 12'h0AB, 12'h0CD, "tcempty");
    chk("tcempty.count", 32'(count), 32'd1);

    // asynchronous reset while a load is pending
    step(1, 0, 0, 12'h222, 12'h333, "prerst");
    chk("prerst.nLoad", 32'(nLoad), 32'd0);
    #2;
    push = 1'b0;
    nReset = 1'b0;
    #1;
    model_reset();
    chk("rst.nLoad",    32'(nLoad), 32'd1);
    chk("rst.count",    32'(count), 32'd0);
    chk("rst.loadAddr", 32'(loadAddr), 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    step(0, 1, 0, '0, '0, "postrst");
    chk("postrst.unf", 32'(underflow), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 6, WIDTH'($urandom), WIDTH'($urandom), "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
